// File: rtl/forward_pkg.sv
// rtl/forward_pkg.sv - shared types and constants for the EX-stage forwarding unit
//
// Purpose : select encodings, shadow-slot record and slot-validity helper used by
//           forward_ctrl_unit and fwd_slot_cmp.
// Ports   : none (package).
// Config  : none here; the load-use stall option FWD_LOAD_USE_STALL_EN lives in
//           forward_ctrl_unit.
package forward_pkg;

   localparam int FWD_REG_ADDR_W = 5;
   localparam int FWD_SEL_W      = 2;

   // EX operand mux select encoding
   localparam logic [1:0] FWD_SEL_RF   = 2'd0;  // register-file read data
   localparam logic [1:0] FWD_SEL_MEM  = 2'd1;  // EX/MEM ALU result
   localparam logic [1:0] FWD_SEL_WB   = 2'd2;  // value being written back
   localparam logic [1:0] FWD_SEL_LOAD = 2'd3;  // load data currently in MEM

   // One shadow-pipeline slot: destination, writes-RF, is-load
   typedef struct packed {
      logic [FWD_REG_ADDR_W-1:0] dest;
      logic                      wr;
      logic                      rd;
   } fwd_slot_t;

   localparam fwd_slot_t FWD_SLOT_EMPTY = '0;

   // A slot can only supply a value if it writes a register other than $0
   function automatic logic slot_valid(input fwd_slot_t s);
      return s.wr && (s.dest != '0);
   endfunction

endpackage

// File: rtl/forward_ctrl_unit_if.sv
// rtl/forward_ctrl_unit_if.sv - ID-side inputs and EX-side outputs of the forwarding unit
//
// Purpose : bundles the ID-stage decode info, flush/hold controls and the
//           forwarding selects / stall into one interface.
// Modports: master - pipeline side (drives ID_*, Flush, HoldIn; reads selects, Stall)
//           slave  - forwarding unit side (the reverse)
// Signals : ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegDest, ID_RegWrite, ID_MemRead,
//           Flush, HoldIn, FWMuxAControl, FWMuxBControl, Stall
interface forward_ctrl_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int SEL_W      = 2
);

   logic [REG_ADDR_W-1:0] ID_Rs;
   logic [REG_ADDR_W-1:0] ID_Rt;
   logic                  ID_UsesRs;
   logic                  ID_UsesRt;
   logic [REG_ADDR_W-1:0] ID_RegDest;
   logic                  ID_RegWrite;
   logic                  ID_MemRead;
   logic                  Flush;
   logic                  HoldIn;
   logic [SEL_W-1:0]      FWMuxAControl;
   logic [SEL_W-1:0]      FWMuxBControl;
   logic                  Stall;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegDest, ID_RegWrite, ID_MemRead,
      output Flush, HoldIn,
      input  FWMuxAControl, FWMuxBControl, Stall
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegDest, ID_RegWrite, ID_MemRead,
      input  Flush, HoldIn,
      output FWMuxAControl, FWMuxBControl, Stall
   );

endinterface

// File: rtl/fwd_slot_cmp.sv
// rtl/fwd_slot_cmp.sv - one source register against the EX/MEM shadow slots
//
// Purpose : produces the forwarding select for one EX operand.
// Ports   : src  in  source register number read by the instruction in ID
//           uses in  the instruction actually reads src
//           exs  in  shadow slot of the instruction now in EX
//           mems in  shadow slot of the instruction now in MEM
//           sel  out select (RF / MEM / WB / LOAD)
module fwd_slot_cmp
   import forward_pkg::*;
#(
   parameter int REG_ADDR_W = FWD_REG_ADDR_W,
   parameter int SEL_W      = FWD_SEL_W
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  uses,
   input  fwd_slot_t             exs,
   input  fwd_slot_t             mems,
   output logic [SEL_W-1:0]      sel
);

   // Whether the MEM-slot instruction is a load does not change the select:
   // by WB its result is on the write-back path either way.
   logic unused_mem_rd;
   assign unused_mem_rd = mems.rd;

   always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      if (uses) begin
         // The nearest producer (EX) holds the newest value, so it is tested first.
         if (slot_valid(exs) && (src == exs.dest)) begin
            sel = exs.rd ? SEL_W'(FWD_SEL_LOAD) : SEL_W'(FWD_SEL_MEM);
         end else if (slot_valid(mems) && (src == mems.dest)) begin
            sel = SEL_W'(FWD_SEL_WB);
         end
      end
   end

endmodule

// File: rtl/forward_ctrl_unit.sv
// rtl/forward_ctrl_unit.sv - EX-stage forwarding selects and load-use stall for a 5-stage MIPS
//
// Purpose : shadows dest/RegWrite/MemRead of the EX and MEM instructions, compares
//           them with the sources of the ID instruction and registers the selects
//           so they line up with that instruction's EX cycle.
// Ports   : Clock  in  pipeline clock
//           Reset  in  synchronous active-high reset
//           bus    slave modport of forward_ctrl_unit_if (ID inputs, Flush, HoldIn,
//                  FWMuxAControl, FWMuxBControl, Stall)
// Config  : FWD_LOAD_USE_STALL_EN - when defined, a load in EX feeding the ID
//           instruction raises Stall for one cycle and inserts a bubble, so the
//           load data is taken from WB (select 2) and select 3 never appears.
module forward_ctrl_unit
   import forward_pkg::*;
#(
   parameter int REG_ADDR_W = FWD_REG_ADDR_W,
   parameter int SEL_W      = FWD_SEL_W
) (
   input  logic                Clock,
   input  logic                Reset,
   forward_ctrl_unit_if.slave  bus
);

   fwd_slot_t        exs_q,   exs_d;
   fwd_slot_t        mems_q,  mems_d;
   logic [SEL_W-1:0] sel_a_q, sel_a_d;
   logic [SEL_W-1:0] sel_b_q, sel_b_d;
   logic [SEL_W-1:0] sel_a_nxt;
   logic [SEL_W-1:0] sel_b_nxt;
   logic             stall;

   fwd_slot_cmp #(
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
   ) u_cmp_a (
      .src  (bus.ID_Rs),
      .uses (bus.ID_UsesRs),
      .exs  (exs_q),
      .mems (mems_q),
      .sel  (sel_a_nxt)
   );

   fwd_slot_cmp #(
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
   ) u_cmp_b (
      .src  (bus.ID_Rt),
      .uses (bus.ID_UsesRt),
      .exs  (exs_q),
      .mems (mems_q),
      .sel  (sel_b_nxt)
   );

`ifdef FWD_LOAD_USE_STALL_EN
   // A LOAD select can only come from a valid load in EX matching a used source,
   // which is exactly the load-use hazard.
   assign stall = ~Reset & ((sel_a_nxt == SEL_W'(FWD_SEL_LOAD)) |
                            (sel_b_nxt == SEL_W'(FWD_SEL_LOAD)));
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      exs_d   = exs_q;
      mems_d  = mems_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (!bus.HoldIn) begin
         mems_d = exs_q;
         if (stall) begin
            exs_d = FWD_SLOT_EMPTY;
         end else begin
            exs_d.dest = bus.ID_RegDest;
            exs_d.wr   = bus.ID_RegWrite & ~bus.Flush;
            exs_d.rd   = bus.ID_MemRead  & ~bus.Flush;
         end
         // A squashed or bubbled instruction reaches EX as a no-op reading the RF.
         if (stall || bus.Flush) begin
            sel_a_d = SEL_W'(FWD_SEL_RF);
            sel_b_d = SEL_W'(FWD_SEL_RF);
         end else begin
            sel_a_d = sel_a_nxt;
            sel_b_d = sel_b_nxt;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         exs_q   <= FWD_SLOT_EMPTY;
         mems_q  <= FWD_SLOT_EMPTY;
         sel_a_q <= SEL_W'(FWD_SEL_RF);
         sel_b_q <= SEL_W'(FWD_SEL_RF);
      end else begin
         exs_q   <= exs_d;
         mems_q  <= mems_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign bus.FWMuxAControl = sel_a_q;
   assign bus.FWMuxBControl = sel_b_q;
   assign bus.Stall         = stall;

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb/tb_forward_ctrl_unit.sv - scoreboard bench for forward_ctrl_unit
module tb_forward_ctrl_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   forward_ctrl_unit_if bus ();

   forward_ctrl_unit dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   // Writers still in flight, youngest first: [0] is in EX, [1] is in MEM.
   typedef struct {
      int dest;
      bit wr;
      bit ld;
   } prod_t;
   prod_t inflight[$];

   typedef struct {
      int a;
      int b;
      bit stall;
      int cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int m_sel_a = 0;
   int m_sel_b = 0;

   function automatic int ref_sel(input int src, input bit uses);
      if (!uses || src == 0) return 0;
      if (inflight[0].wr && inflight[0].dest == src) return inflight[0].ld ? 3 : 1;
      if (inflight[1].wr && inflight[1].dest == src) return 2;
      return 0;
   endfunction

   function automatic bit ref_stall(input int rs, input int rt, input bit urs,
                                    input bit urt, input bit r);
`ifdef FWD_LOAD_USE_STALL_EN
      return !r && (ref_sel(rs, urs) == 3 || ref_sel(rt, urt) == 3);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      prod_t e;
      e = '{0, 1'b0, 1'b0};
      inflight.delete();
      inflight.push_back(e);
      inflight.push_back(e);
      m_sel_a = 0;
      m_sel_b = 0;
   endtask

   // Present one cycle of ID inputs, record what the DUT must show this cycle,
   // then advance the model across the coming clock edge.
   task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit wr, input bit mr,
                       input bit fl, input bit hold, input bit r, output bit stalled);
      exp_t  e;
      prod_t n;
      int    na, nb;
      bus.ID_Rs       = rs[4:0];
      bus.ID_Rt       = rt[4:0];
      bus.ID_UsesRs   = urs;
      bus.ID_UsesRt   = urt;
      bus.ID_RegDest  = dest[4:0];
      bus.ID_RegWrite = wr;
      bus.ID_MemRead  = mr;
      bus.Flush       = fl;
      bus.HoldIn      = hold;
      rst             = r;
      stalled = ref_stall(rs, rt, urs, urt, r);
      e = '{m_sel_a, m_sel_b, stalled, cyc};
      sb.push_back(e);
      if (r) begin
         model_clear();
      end else if (!hold) begin
         na = ref_sel(rs, urs);
         nb = ref_sel(rt, urt);
         if (stalled) n = '{0, 1'b0, 1'b0};
         else         n = '{dest, wr & !fl, mr & !fl};
         inflight.push_front(n);
         void'(inflight.pop_back());
         m_sel_a = (stalled || fl) ? 0 : na;
         m_sel_b = (stalled || fl) ? 0 : nb;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Issue one instruction; while the model says it is stalled, re-present it
   // as the frozen IF/ID register would.
   task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit wr, input bit mr);
      bit s;
      int n;
      n = 0;
      do begin
         step(rs, rt, urs, urt, dest, wr, mr, 1'b0, 1'b0, 1'b0, s);
         n++;
      end while (s && n < 4);
   endtask

   task automatic nop();
      issue(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);   // sll $0,$0,0 : writes $0
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (bus.FWMuxAControl !== 2'(e.a)) begin
            errors++;
            $display("FAIL sel_a cyc=%0d got=%0d exp=%0d", e.cyc, bus.FWMuxAControl, e.a);
         end
         checks++;
         if (bus.FWMuxBControl !== 2'(e.b)) begin
            errors++;
            $display("FAIL sel_b cyc=%0d got=%0d exp=%0d", e.cyc, bus.FWMuxBControl, e.b);
         end
         checks++;
         if (bus.Stall !== e.stall) begin
            errors++;
            $display("FAIL stall cyc=%0d got=%0b exp=%0b", e.cyc, bus.Stall, e.stall);
         end
      end
   end

   initial begin
      bit s;
      bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UsesRs = 1'b0; bus.ID_UsesRt = 1'b0;
      bus.ID_RegDest = '0; bus.ID_RegWrite = 1'b0; bus.ID_MemRead = 1'b0;
      bus.Flush = 1'b0; bus.HoldIn = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      step(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);   // reset state

      // add $3,$1,$2 ; sub $4,$3,$5
      issue(1, 2, 1, 1, 3, 1, 0);
      issue(3, 5, 1, 1, 4, 1, 0);
      nop(); nop();
      // add $3 ; nop ; or $6,$0,$3
      issue(1, 2, 1, 1, 3, 1, 0);
      nop();
      issue(0, 3, 1, 1, 6, 1, 0);
      nop(); nop();
      // add $3 ; add $3 ; and $7,$3,$3
      issue(1, 2, 1, 1, 3, 1, 0);
      issue(4, 5, 1, 1, 3, 1, 0);
      issue(3, 3, 1, 1, 7, 1, 0);
      nop(); nop();
      // lw $8,0($1) ; add $9,$8,$8
      issue(1, 8, 1, 0, 8, 1, 1);
      issue(8, 8, 1, 1, 9, 1, 0);
      nop(); nop();
      // flushed add $3 ; sub reading $3
      step(1, 2, 1, 1, 3, 1, 0, 1'b1, 1'b0, 1'b0, s);
      issue(3, 3, 1, 1, 4, 1, 0);
      nop(); nop();
      // add $3 ; hold 3 cycles (one with Flush) ; sub $4,$3,$5
      issue(1, 2, 1, 1, 3, 1, 0);
      step(3, 5, 1, 1, 4, 1, 0, 1'b0, 1'b1, 1'b0, s);
      step(3, 5, 1, 1, 4, 1, 0, 1'b1, 1'b1, 1'b0, s);
      step(3, 5, 1, 1, 4, 1, 0, 1'b0, 1'b1, 1'b0, s);
      issue(3, 5, 1, 1, 4, 1, 0);
      issue(4, 3, 1, 1, 6, 1, 0);
      // reset with valid slots (and HoldIn) ; consumer of old dest
      issue(1, 2, 1, 1, 3, 1, 0);
      issue(1, 2, 1, 1, 5, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, s);
      issue(3, 5, 1, 1, 6, 1, 0);
      nop();

      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0),
              1'($urandom_range(0, 49) == 0), s);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, s);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
